// File: rtl/check_msg_gen_pkg.sv
// Shared types, sizes and magnitude helpers for the offset-min-sum
// check-message generator.
package check_msg_gen_pkg;

  localparam int BITS   = 8;
  localparam int DMAX   = 10;
  localparam int ROWS   = 46;
  localparam int OFFSET = 1;
  localparam int MAG_W  = BITS - 1;
  localparam int IDX_W  = $clog2(DMAX);
  localparam int ROW_W  = $clog2(ROWS);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT2
  } state_t;

  typedef struct packed {
    logic [MAG_W-1:0] m1;
    logic [MAG_W-1:0] m2;
    logic [IDX_W-1:0] idx;
    logic [DMAX-1:0]  sign;
    logic             par;
  } cnu_entry_t;

  typedef logic [DMAX-1:0][BITS-1:0] msg_vec_t;

  // Subtract beta from a signed magnitude; negatives and values <= beta become 0.
  function automatic logic [MAG_W-1:0] offset_mag(input logic [BITS-1:0] v);
    logic signed [BITS-1:0] sv;
    logic signed [BITS-1:0] off_s;
    logic        [BITS-1:0] diff;
    sv    = v;
    off_s = BITS'(OFFSET);
    diff  = v - BITS'(OFFSET);
    if (sv > off_s) return diff[MAG_W-1:0];
    else            return '0;
  endfunction

  function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
    return idx >= IDX_W'(DMAX);
  endfunction

  function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] idx);
    return idx_bad(idx) ? IDX_W'(DMAX - 1) : idx;
  endfunction

endpackage

// File: rtl/check_msg_gen_if.sv
// CNU-result input, row-read request and expanded-message output bundle.
interface check_msg_gen_if;
  import check_msg_gen_pkg::*;

  logic             in_valid;
  logic             in_sel;
  logic [BITS-1:0]  in_min1;
  logic [BITS-1:0]  in_min2;
  logic [IDX_W-1:0] in_idx;
  logic [DMAX-1:0]  in_sign;
  logic [ROW_W-1:0] in_row;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic             out_valid;
  msg_vec_t         out_msg;
  logic             err;

  modport master (
    output in_valid, in_sel, in_min1, in_min2, in_idx, in_sign, in_row,
    output rd_en, rd_row,
    input  out_valid, out_msg, err
  );

  modport slave (
    input  in_valid, in_sel, in_min1, in_min2, in_idx, in_sign, in_row,
    input  rd_en, rd_row,
    output out_valid, out_msg, err
  );

endinterface

// File: rtl/check_msg_gen_expand.sv
// Expands one compressed check-node entry into DMAX signed messages.
module check_msg_gen_expand
  import check_msg_gen_pkg::*;
(
  input  cnu_entry_t entry_i,
  output msg_vec_t   msg_o
);

  for (genvar j = 0; j < DMAX; j++) begin : g_lane
    logic [BITS-1:0] mag;
    logic            neg;
    // The min1 edge gets min2; sign excludes the edge's own input sign.
    assign mag      = {1'b0, (entry_i.idx == IDX_W'(j)) ? entry_i.m2 : entry_i.m1};
    assign neg      = entry_i.par ^ entry_i.sign[j];
    assign msg_o[j] = neg ? -mag : mag;
  end

endmodule

// File: rtl/check_msg_gen.sv
// Collects two-pass CNU results per row, stores offset-corrected compressed
// entries, and expands a requested row into check-to-variable messages.
module check_msg_gen
  import check_msg_gen_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  check_msg_gen_if.slave bus
);

  state_t           state_q, state_d;
  logic [MAG_W-1:0] m1_q, m1_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DMAX-1:0]  sign_q, sign_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic             pass0, pass1;

  cnu_entry_t       entries_q [ROWS];
  cnu_entry_t       wr_entry;
  cnu_entry_t       rd_entry;
  msg_vec_t         rd_msgs;
  msg_vec_t         out_msg_q;
  logic             out_valid_q;

  assign pass0 = bus.in_valid & ~bus.in_sel;
  assign pass1 = bus.in_valid &  bus.in_sel;

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    m1_d    = m1_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    row_d   = row_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pass0) begin
          m1_d    = offset_mag(bus.in_min1);
          idx_d   = clamp_idx(bus.in_idx);
          sign_d  = bus.in_sign;
          row_d   = bus.in_row;
          err_d   = idx_bad(bus.in_idx);
          state_d = ST_WAIT2;
        end else if (pass1) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (pass1) begin
          wr_en   = 1'b1;
          state_d = ST_IDLE;
        end else if (pass0) begin
          // Orphaned pass 0 is dropped; the new one takes its place.
          m1_d   = offset_mag(bus.in_min1);
          idx_d  = clamp_idx(bus.in_idx);
          sign_d = bus.in_sign;
          row_d  = bus.in_row;
          err_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m1_q    <= '0;
      idx_q   <= '0;
      sign_q  <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m1_q    <= m1_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    wr_entry.m1   = m1_q;
    wr_entry.m2   = offset_mag(bus.in_min2);
    wr_entry.idx  = idx_q;
    wr_entry.sign = sign_q;
    wr_entry.par  = ^sign_q;
  end

  // NOTE: storage is a flop array with async clear because unwritten rows
  // must read as zero after reset; a RAM macro could not provide that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) entries_q[r] <= '0;
    end else if (wr_en && (row_q < ROW_W'(ROWS))) begin
      entries_q[row_q] <= wr_entry;
    end
  end

  // Read sees pre-edge contents, giving read-first behaviour on a collision.
  assign rd_entry = (bus.rd_row < ROW_W'(ROWS)) ? entries_q[bus.rd_row] : '0;

  check_msg_gen_expand u_expand (
    .entry_i (rd_entry),
    .msg_o   (rd_msgs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_msg_q   <= '0;
    end else begin
      out_valid_q <= bus.rd_en;
      if (bus.rd_en) out_msg_q <= rd_msgs;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_msg   = out_msg_q;
  assign bus.err       = err_q;

endmodule
